// File: rtl/cg_pkg.sv
// Shared definitions for the conjugate-gradient iteration sequencer.
package cg_pkg;

  // Sequencer state encoding.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StInit   = 3'd1,
    StRsold  = 3'd2,
    StMatvec = 3'd3,
    StXr     = 3'd4,
    StPupd   = 3'd5,
    StCheck  = 3'd6,
    StDone   = 3'd7
  } cg_state_e;

  // fp32 convergence threshold applied to r.r.
  localparam logic [31:0] CG_TOL_DEFAULT = 32'h283424DC;

  // Number of cycles the Alu and both stages are held in reset before each iteration.
  localparam int unsigned CG_INIT_CYCLES = 2;

  // Memory words needed to hold one vector of num_eq elements.
  function automatic int unsigned cg_words(input int unsigned num_eq,
                                           input int unsigned units);
    return (num_eq + units - 1) / units;
  endfunction

endpackage

// File: rtl/cg_addr_gen.sv
// Word-address streamer: after a start pulse, emits WORDS consecutive addresses
// 0..WORDS-1 with rd_en high, then drops rd_en and returns to address 0.
module cg_addr_gen #(
  parameter int unsigned WORDS  = 2,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  logic              active_q;
  logic [ADDR_W-1:0] addr_q;

  // Address counter: runs once per start, clear aborts a partial stream.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active_q <= 1'b0;
      addr_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      addr_q   <= '0;
    end else if (active_q) begin
      if (addr_q == LAST_ADDR) begin
        active_q <= 1'b0;
        addr_q   <= '0;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Strobe and address follow the counter; wrap marks the final word.
  always_comb begin
    rd_en   = active_q;
    rd_addr = addr_q;
    wrap    = active_q && (addr_q == LAST_ADDR);
  end

endmodule

// File: rtl/cg_iteration_sequencer.sv
// Iteration sequencer for the conjugate-gradient Alu: drives stage resets, streams
// vector-memory reads, tracks Alu handshakes and decides convergence or timeout.
module cg_iteration_sequencer
  import cg_pkg::*;
#(
  parameter int unsigned NUM_EQ      = 10,
  parameter int unsigned NO_OF_UNITS = 8,
  parameter int unsigned MAX_ITER    = 64,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter int unsigned ADDR_W      = 16,
  parameter logic [31:0] TOL         = CG_TOL_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_i,
  input  logic              vxv1_finish_i,
  input  logic              mxv1_finish_i,
  input  logic              xr_done_i,
  input  logic              p_we_i,
  input  logic              rsnew_valid_i,
  input  logic [31:0]       rsnew_i,
  output logic              alu_reset_o,
  output logic              reset_vxv1_o,
  output logic              reset_mxv1_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              bank_sel_o,
  output logic [15:0]       iter_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              converged_o,
  output logic              timeout_o
);

  localparam int unsigned WORDS  = cg_words(NUM_EQ, NO_OF_UNITS);
  localparam int unsigned CNT_W  = $clog2(WORDS + 1);
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned INIT_W = $clog2(CG_INIT_CYCLES + 1);

  cg_state_e         state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [15:0]       iter_q, iter_d;
  logic              bank_q, bank_d;
  logic              conv_q, conv_d;
  logic              tout_q, tout_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0]  pwe_cnt_q, pwe_cnt_d;
  logic [31:0]       rsnew_q, rsnew_d;
  logic              rs_seen_q, rs_seen_d;

  logic              wait_state;
  logic              rs_conv;
  logic              ag_start;
  logic              ag_clear;
  logic              ag_rd_en;
  logic [ADDR_W-1:0] ag_rd_addr;
  logic              ag_wrap;
  logic              unused_sig;

  cg_addr_gen #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .start   (ag_start),
    .clear   (ag_clear),
    .rd_en   (ag_rd_en),
    .rd_addr (ag_rd_addr),
    .wrap    (ag_wrap)
  );

  // r.r is non-negative, so the sign bit carries no information.
  assign rs_conv    = rsnew_q[30:0] < TOL[30:0];
  assign unused_sig = ^{ag_wrap, rsnew_q[31]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      init_cnt_q <= '0;
      iter_q     <= '0;
      bank_q     <= 1'b0;
      conv_q     <= 1'b0;
      tout_q     <= 1'b0;
      wdog_q     <= '0;
      pwe_cnt_q  <= '0;
      rsnew_q    <= '0;
      rs_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      iter_q     <= iter_d;
      bank_q     <= bank_d;
      conv_q     <= conv_d;
      tout_q     <= tout_d;
      wdog_q     <= wdog_d;
      pwe_cnt_q  <= pwe_cnt_d;
      rsnew_q    <= rsnew_d;
      rs_seen_q  <= rs_seen_d;
    end
  end

  // Next-state: handshake sequencing, rsnew/p_we bookkeeping, iteration decision, watchdog.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    iter_d     = iter_q;
    bank_d     = bank_q;
    conv_d     = conv_q;
    tout_d     = tout_q;
    pwe_cnt_d  = pwe_cnt_q;
    rsnew_d    = rsnew_q;
    rs_seen_d  = rs_seen_q;
    ag_start   = 1'b0;
    wait_state = state_q inside {StRsold, StMatvec, StXr, StPupd};

    // rsnew may arrive anywhere in the Alu phases; the latest value wins.
    if (wait_state && rsnew_valid_i) begin
      rsnew_d   = rsnew_i;
      rs_seen_d = 1'b1;
    end
    // Saturating count, so surplus p writes cannot disturb the exit test.
    if ((state_q == StPupd) && p_we_i && (pwe_cnt_q != CNT_W'(WORDS))) begin
      pwe_cnt_d = pwe_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (go_i) begin
          state_d    = StInit;
          init_cnt_d = '0;
          iter_d     = '0;
          bank_d     = 1'b0;
          conv_d     = 1'b0;
          tout_d     = 1'b0;
          pwe_cnt_d  = '0;
          rs_seen_d  = 1'b0;
        end
      end
      StInit: begin
        if (init_cnt_q == INIT_W'(CG_INIT_CYCLES - 1)) begin
          state_d    = StRsold;
          init_cnt_d = '0;
          ag_start   = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StRsold: begin
        if (vxv1_finish_i) state_d = StMatvec;
      end
      StMatvec: begin
        if (mxv1_finish_i) state_d = StXr;
      end
      StXr: begin
        if (xr_done_i) state_d = StPupd;
      end
      StPupd: begin
        if ((pwe_cnt_d == CNT_W'(WORDS)) && rs_seen_d) state_d = StCheck;
      end
      StCheck: begin
        iter_d = iter_q + 16'd1;
        if (rs_conv) begin
          state_d = StDone;
          conv_d  = 1'b1;
        end else if (iter_q == 16'(MAX_ITER - 1)) begin
          state_d = StDone;
          tout_d  = 1'b1;
        end else begin
          state_d    = StInit;
          bank_d     = ~bank_q;
          init_cnt_d = '0;
          pwe_cnt_d  = '0;
          rs_seen_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog only fires if the wait state would otherwise persist.
    if (wait_state && (state_d == state_q) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1))) begin
      state_d = StDone;
      tout_d  = 1'b1;
      conv_d  = 1'b0;
    end
    wdog_d = (!wait_state || (state_d != state_q)) ? '0 : wdog_q + 1'b1;
  end

  // Abort an unfinished read stream when RSOLD is left early.
  assign ag_clear = (state_q == StRsold) && (state_d != StRsold);

  // Moore outputs decoded from the current state.
  always_comb begin
    alu_reset_o  = 1'b0;
    reset_vxv1_o = 1'b1;
    reset_mxv1_o = 1'b1;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state_q)
      StIdle: begin
        alu_reset_o = 1'b1;
        busy_o      = 1'b0;
      end
      StInit:  alu_reset_o = 1'b1;
      StRsold: reset_vxv1_o = 1'b0;
      StMatvec, StXr, StPupd, StCheck: begin
        reset_vxv1_o = 1'b0;
        reset_mxv1_o = 1'b0;
      end
      StDone: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      default: begin
        alu_reset_o = 1'b1;
        busy_o      = 1'b0;
      end
    endcase
    rd_en_o     = ag_rd_en;
    rd_addr_o   = ag_rd_addr;
    bank_sel_o  = bank_q;
    iter_o      = iter_q;
    converged_o = conv_q;
    timeout_o   = tout_q;
  end

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Self-checking bench for cg_iteration_sequencer: a scripted Alu stub drives the
// handshakes; outcomes come from a table and from a per-scenario reference model.
module tb_cg_iteration_sequencer;

  localparam int unsigned MAX_ITER = 3;
  localparam int unsigned WDOG     = 16;
  localparam int unsigned WORDS    = 2;
  localparam logic [31:0] TOL      = 32'h283424DC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go_i = 1'b0;
  logic        vxv1_finish_i = 1'b0;
  logic        mxv1_finish_i = 1'b0;
  logic        xr_done_i = 1'b0;
  logic        p_we_i = 1'b0;
  logic        rsnew_valid_i = 1'b0;
  logic [31:0] rsnew_i = '0;
  logic        alu_reset_o, reset_vxv1_o, reset_mxv1_o, rd_en_o;
  logic [15:0] rd_addr_o;
  logic        bank_sel_o;
  logic [15:0] iter_o;
  logic        busy_o, done_o, converged_o, timeout_o;

  int total = 0;
  int bad   = 0;

  cg_iteration_sequencer #(
    .NUM_EQ      (10),
    .NO_OF_UNITS (8),
    .MAX_ITER    (MAX_ITER),
    .WDOG_CYCLES (WDOG),
    .ADDR_W      (16),
    .TOL         (TOL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go_i          (go_i),
    .vxv1_finish_i (vxv1_finish_i),
    .mxv1_finish_i (mxv1_finish_i),
    .xr_done_i     (xr_done_i),
    .p_we_i        (p_we_i),
    .rsnew_valid_i (rsnew_valid_i),
    .rsnew_i       (rsnew_i),
    .alu_reset_o   (alu_reset_o),
    .reset_vxv1_o  (reset_vxv1_o),
    .reset_mxv1_o  (reset_mxv1_o),
    .rd_en_o       (rd_en_o),
    .rd_addr_o     (rd_addr_o),
    .bank_sel_o    (bank_sel_o),
    .iter_o        (iter_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .converged_o   (converged_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs [3];
    int          rs_slot;   // >=0: with that p_we pulse; -1: in RSOLD; -2: after all pulses
    bit          extra;     // one surplus p_we pulse after the last real one
    int          exp_iter;
    bit          exp_conv;
    bit          exp_to;
  } scen_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_go();
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_flags"}, {23'd0, alu_reset_o, reset_vxv1_o, reset_mxv1_o, rd_en_o, bank_sel_o,
                          busy_o, done_o, converged_o, timeout_o}, 32'h1C0);
    chk({tag, "_addr_iter"}, {rd_addr_o, iter_o}, 32'h0);
  endtask

  // Reference outcome: first iteration whose |rsnew| is below TOL converges.
  task automatic ref_model(input scen_t s, output int it, output bit cv, output bit to);
    bit found;
    found = 1'b0;
    it = int'(MAX_ITER);
    for (int k = 0; k < int'(MAX_ITER); k++) begin
      if (!found && ((s.rs[k] & 32'h7FFF_FFFF) < (TOL & 32'h7FFF_FFFF))) begin
        found = 1'b1;
        it = k + 1;
      end
    end
    cv = found;
    to = !found;
  endtask

  function automatic scen_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input int slot, input bit extra, input int it, input bit cv,
                               input bit to);
    scen_t s;
    s.rs[0] = a; s.rs[1] = b; s.rs[2] = c;
    s.rs_slot = slot; s.extra = extra; s.exp_iter = it; s.exp_conv = cv; s.exp_to = to;
    return s;
  endfunction

  function automatic logic [31:0] pick_rs();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = TOL - 32'd1;
      1: v = TOL;
      2: v = TOL + 32'd1;
      3: v = $urandom & 32'h007F_FFFF;
      default: v = $urandom;
    endcase
    v[31] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One Alu iteration as seen from the stub; returns when the DUT is in INIT or DONE.
  task automatic alu_iter(input int k, input int d_rs, input int d_mv, input int d_xr,
                          input logic [31:0] rs, input int rs_slot, input bit extra,
                          input bit stop_in_xr, output bit ended);
    bit ok;
    int gap;
    ended = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (!reset_vxv1_o && busy_o) ok = 1'b1;
      else tick();
    end
    chk($sformatf("it%0d_rsold_reached", k), {31'd0, ok}, 32'd1);
    if (!ok) begin
      ended = 1'b1;
      return;
    end
    chk($sformatf("it%0d_bank_sel", k), {31'd0, bank_sel_o}, 32'(k % 2));
    chk($sformatf("it%0d_iter", k), {16'd0, iter_o}, 32'(k));
    chk($sformatf("it%0d_rsold_resets", k), {29'd0, alu_reset_o, reset_mxv1_o, busy_o}, 32'd3);
    if (rs_slot == -1) begin
      rsnew_valid_i = 1'b1;
      rsnew_i = rs;
    end
    for (int j = 0; j <= d_rs; j++) begin
      chk($sformatf("it%0d_rd_en_%0d", k, j), {31'd0, rd_en_o}, (j < int'(WORDS)) ? 1 : 0);
      chk($sformatf("it%0d_rd_addr_%0d", k, j), {16'd0, rd_addr_o},
          (j < int'(WORDS)) ? 32'(j) : 32'd0);
      if (j == d_rs) vxv1_finish_i = 1'b1;
      tick();
      rsnew_valid_i = 1'b0;
    end
    repeat (d_mv) tick();
    mxv1_finish_i = 1'b1;
    if (stop_in_xr) begin
      tick();
      tick();
      return;
    end
    repeat (d_xr) tick();
    xr_done_i = 1'b1;
    repeat (3) tick();
    for (int p = 0; p < int'(WORDS); p++) begin
      p_we_i = 1'b1;
      if (rs_slot == p) begin
        rsnew_valid_i = 1'b1;
        rsnew_i = rs;
      end
      tick();
      p_we_i = 1'b0;
      rsnew_valid_i = 1'b0;
      if (p < int'(WORDS) - 1) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) tick();
      end
    end
    if (extra) begin
      p_we_i = 1'b1;
      tick();
      p_we_i = 1'b0;
    end
    if (rs_slot == -2) begin
      repeat (2) tick();
      // All p words are in, but without rsnew the DUT must still be waiting.
      chk($sformatf("it%0d_waits_rsnew", k), {29'd0, done_o, alu_reset_o, busy_o}, 32'd1);
      rsnew_valid_i = 1'b1;
      rsnew_i = rs;
      tick();
      rsnew_valid_i = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done_o || (busy_o && alu_reset_o)) ok = 1'b1;
      else tick();
    end
    chk($sformatf("it%0d_end_reached", k), {31'd0, ok}, 32'd1);
    ended = done_o || !ok;
    vxv1_finish_i = 1'b0;
    mxv1_finish_i = 1'b0;
    xr_done_i = 1'b0;
  endtask

  task automatic run_scen(input scen_t s, input int idx, input bit rnd);
    int  passes;
    bit  ended;
    int  d_rs, d_mv, d_xr;
    pulse_go();
    chk($sformatf("s%0d_go_clears", idx), {13'd0, done_o, converged_o, timeout_o, iter_o}, 32'd0);
    passes = 0;
    ended = 1'b0;
    for (int k = 0; k < int'(MAX_ITER); k++) begin
      if (!ended) begin
        d_rs = rnd ? int'($urandom_range(2, 4)) : 3;
        d_mv = rnd ? int'($urandom_range(0, 4)) : 3;
        d_xr = rnd ? int'($urandom_range(0, 4)) : 3;
        alu_iter(k, d_rs, d_mv, d_xr, s.rs[k], s.rs_slot, s.extra, 1'b0, ended);
        passes++;
      end
    end
    chk($sformatf("s%0d_init_passes", idx), 32'(passes), 32'(s.exp_iter));
    chk($sformatf("s%0d_done", idx), {29'd0, done_o, busy_o, reset_vxv1_o & reset_mxv1_o},
        32'd5);
    chk($sformatf("s%0d_iter", idx), {16'd0, iter_o}, 32'(s.exp_iter));
    chk($sformatf("s%0d_converged", idx), {31'd0, converged_o}, {31'd0, s.exp_conv});
    chk($sformatf("s%0d_timeout", idx), {31'd0, timeout_o}, {31'd0, s.exp_to});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    scen_t tbl [8];
    scen_t s;
    int    n;
    bit    ended;
    int    e_it;
    bit    e_cv, e_to;

    tbl[0] = mk(32'h0, 32'h0, 32'h0, 1, 1'b0, 1, 1'b1, 1'b0);
    tbl[1] = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 1'b0, 3, 1'b0, 1'b1);
    tbl[2] = mk(32'h283424DB, 32'h0, 32'h0, -1, 1'b0, 1, 1'b1, 1'b0);
    tbl[3] = mk(32'h283424DC, 32'h283424DB, 32'h0, -2, 1'b0, 2, 1'b1, 1'b0);
    tbl[4] = mk(32'hA83424DB, 32'h3F800000, 32'h3F800000, 0, 1'b0, 1, 1'b1, 1'b0);
    tbl[5] = mk(32'hBF800000, 32'h3F800000, 32'h00000001, 1, 1'b1, 3, 1'b1, 1'b0);
    tbl[6] = mk(32'h0, 32'h0, 32'h0, 1, 1'b1, 1, 1'b1, 1'b0);
    tbl[7] = mk(32'hA83424DC, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 3, 1'b0, 1'b1);

    repeat (3) tick();
    chk_reset_state("reset");
    reset = 1'b0;
    tick();
    chk_reset_state("idle");

    for (int i = 0; i < 8; i++) run_scen(tbl[i], i, 1'b0);

    // Watchdog in MATVEC; a go pulse mid-wait must be ignored.
    pulse_go();
    n = 0;
    while (!(busy_o && !reset_vxv1_o) && n < 40) begin
      tick();
      n++;
    end
    vxv1_finish_i = 1'b1;
    n = 0;
    while (reset_mxv1_o && n < 40) begin
      tick();
      n++;
    end
    chk("wdog_rd_stream_aborted", {31'd0, rd_en_o}, 32'd0);
    n = 0;
    while (!done_o && n < 100) begin
      go_i = (n == 5);
      tick();
      n++;
    end
    go_i = 1'b0;
    chk("wdog_cycles", 32'(n), 32'(WDOG));
    chk("wdog_flags", {29'd0, done_o, timeout_o, converged_o}, 32'd6);
    chk("wdog_iter", {16'd0, iter_o}, 32'd0);
    vxv1_finish_i = 1'b0;
    tick();

    // Reset while in XR of the second iteration.
    pulse_go();
    alu_iter(0, 3, 1, 1, 32'h3F800000, 1, 1'b0, 1'b0, ended);
    alu_iter(1, 2, 1, 1, 32'h0, 0, 1'b0, 1'b1, ended);
    chk("xr_pre_reset", {14'd0, bank_sel_o, busy_o, iter_o}, 32'h30001);
    reset = 1'b1;
    tick();
    chk_reset_state("xr_reset");
    reset = 1'b0;
    xr_done_i = 1'b1;
    repeat (5) tick();
    chk("xr_reset_stays_idle", {30'd0, done_o, busy_o}, 32'd0);
    vxv1_finish_i = 1'b0;
    mxv1_finish_i = 1'b0;
    xr_done_i = 1'b0;

    // Randomized scenarios against the reference model.
    for (int r = 0; r < 12; r++) begin
      s.rs[0] = pick_rs();
      s.rs[1] = pick_rs();
      s.rs[2] = pick_rs();
      s.rs_slot = int'($urandom_range(0, 3)) - 2;
      s.extra = 1'($urandom_range(0, 1));
      ref_model(s, e_it, e_cv, e_to);
      s.exp_iter = e_it;
      s.exp_conv = e_cv;
      s.exp_to = e_to;
      run_scen(s, 100 + r, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
